// File: rtl/team_06_sample_packer.sv
// -----------------------------------------------------------------------------
// team_06_sample_packer
//
// Purpose:
//   Packs 8-bit processed audio samples little-endian into 32-bit words, queues
//   the words in a small FIFO and stores them one at a time into a circular
//   SRAM record region through the wishbone_manager single-word write handshake.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low
//   enable        recording enable; low clears packer, FIFO and overflow
//   sample_in     8-bit audio sample
//   sample_valid  one-cycle strobe, sample_in captured this cycle
//   flush         one-cycle strobe, pushes a partial word (zero-padded)
//   busy_i        BUSY_O from wishbone_manager
//   write_o       WRITE_I to manager, single-cycle pulse
//   adr_o         ADR_I to manager (byte address of current ring word)
//   dat_o         CPU_DAT_I to manager
//   sel_o         SEL_I to manager, valid byte lanes
//   level         words currently held in the FIFO (including the in-flight one)
//   overflow      sticky flag, a packed word was dropped because the FIFO was full
//   wrap          one-cycle pulse when adr_o wraps back to BASE_ADDR
// -----------------------------------------------------------------------------
module team_06_sample_packer #(
    parameter logic [31:0] BASE_ADDR  = 32'h3300_0000,
    parameter int          RING_WORDS = 2048,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    input  logic        flush,
    input  logic        busy_i,
    output logic        write_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic [2:0]  level,
    output logic        overflow,
    output logic        wrap
);

    localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]  DEPTH_L   = 3'(FIFO_DEPTH);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (RING_WORDS - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    // Byte-lane enables for a partial word holding k bytes (k = 1..3).
    function automatic logic [3:0] lane_mask(input logic [1:0] k);
        logic [3:0] m;
        case (k)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Expand byte-lane enables to a 32-bit data mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Packer state
    logic [31:0] r_pack;
    logic [1:0]  r_cnt;

    // FIFO storage and control
    logic [31:0]      r_mem_dat [FIFO_DEPTH];
    logic [3:0]       r_mem_sel [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [2:0]       r_level;
    logic             r_overflow;

    // Write FSM and registered outputs
    state_t      r_state;
    logic        r_write;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_wrap;

    // Combinational packing / push / pop decisions
    logic [31:0] w_word;
    logic [2:0]  w_k;
    logic        w_push;
    logic [3:0]  w_push_sel;
    logic [31:0] w_push_dat;
    logic        w_pop;
    logic        w_full;
    logic        w_accept;

    // The sample is merged first so that a coincident flush sees the updated
    // byte count; a word completed by that sample produces a single push.
    always_comb begin
        w_word     = r_pack;
        w_k        = {1'b0, r_cnt};
        w_push     = 1'b0;
        w_push_sel = 4'b0000;
        if (sample_valid) begin
            w_word[{r_cnt, 3'b000} +: 8] = sample_in;
            w_k = w_k + 3'd1;
        end
        if (enable) begin
            if (w_k == 3'd4) begin
                w_push     = 1'b1;
                w_push_sel = 4'b1111;
            end else if (flush && (w_k != 3'd0)) begin
                w_push     = 1'b1;
                w_push_sel = lane_mask(w_k[1:0]);
            end
        end
    end

    // Lanes beyond the valid bytes may hold stale bytes of an earlier word;
    // masking here gives the zero padding.
    assign w_push_dat = w_word & lane_bits(w_push_sel);

    // A word is popped only when its write completes while recording is on;
    // with enable low the FIFO is being cleared anyway.
    assign w_pop    = (r_state == S_WAIT_DONE) && !busy_i && enable;
    assign w_full   = (r_level == DEPTH_L);
    assign w_accept = w_push && (!w_full || w_pop);

    // Packer byte counter
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            r_cnt <= 2'd0;
        end else if (w_push) begin
            r_cnt <= 2'd0;
        end else if (sample_valid) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Packer data register
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_pack <= w_word;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_dat[r_wptr] <= w_push_dat;
            r_mem_sel[r_wptr] <= w_push_sel;
        end
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Write FSM. The head word stays in the FIFO until its write completes,
    // so level counts the in-flight word. A transaction already started runs
    // to completion even if enable drops, and the address still advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_adr   <= BASE_ADDR;
            r_dat   <= 32'd0;
            r_sel   <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_wrap  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && (r_level != 3'd0)) begin
                        r_dat   <= r_mem_dat[r_rptr];
                        r_sel   <= r_mem_sel[r_rptr];
                        r_write <= 1'b1;
                        r_state <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy_i) begin
                        r_state <= S_IDLE;
                        if (r_adr == LAST_ADDR) begin
                            r_adr  <= BASE_ADDR;
                            r_wrap <= 1'b1;
                        end else begin
                            r_adr <= r_adr + 32'd4;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign write_o  = r_write;
    assign adr_o    = r_adr;
    assign dat_o    = r_dat;
    assign sel_o    = r_sel;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_team_06_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_team_06_sample_packer
//
// Bench for team_06_sample_packer with a 4-word ring. A byte-queue model
// predicts every written word and its ring address; a wishbone busy responder
// answers each write_o pulse. Directed sequences cover packing, flush, overflow,
// wrap, enable drop and reset during a transaction.
// -----------------------------------------------------------------------------
module tb_team_06_sample_packer;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          RING  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] LAST  = BASE + 32'(4 * (RING - 1));

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        flush;
    logic        busy_i;
    logic        write_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [2:0]  level;
    logic        overflow;
    logic        wrap;

    team_06_sample_packer #(
        .BASE_ADDR (BASE),
        .RING_WORDS(RING),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .flush       (flush),
        .busy_i      (busy_i),
        .write_o     (write_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .sel_o       (sel_o),
        .level       (level),
        .overflow    (overflow),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  m_bytes[$];
    logic [31:0] m_adr = BASE;

    int          busy_len  = 3;
    bit          busy_hold = 1'b0;
    int          wrap_cnt  = 0;
    logic [31:0] last_dat  = 32'd0;
    logic [31:0] last_adr  = 32'd0;
    logic [3:0]  last_sel  = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_emit();
        wr_t w;
        w.dat = 32'd0;
        w.sel = 4'd0;
        foreach (m_bytes[i]) begin
            w.dat[8*i +: 8] = m_bytes[i];
            w.sel[i]        = 1'b1;
        end
        exp_q.push_back(w);
        m_bytes.delete();
    endtask

    task automatic m_sample(input logic [7:0] b);
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) m_emit();
    endtask

    task automatic m_flush();
        if (m_bytes.size() != 0) m_emit();
    endtask

    function automatic logic [31:0] next_adr(input logic [31:0] a);
        return (a == LAST) ? BASE : a + 32'd4;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic f);
        sample_valid = v;
        sample_in    = b;
        flush        = f;
        if (enable) begin
            if (v) m_sample(b);
            if (f) m_flush();
        end
        step();
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic word(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        drive(1'b1, b0, 1'b0);
        drive(1'b1, b1, 1'b0);
        drive(1'b1, b2, 1'b0);
        drive(1'b1, b3, 1'b0);
    endtask

    task automatic wait_drain(input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            if (level == 3'd0) break;
            step();
        end
        if (k == 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_drain_timeout: level %0d, expected 0", nm, level);
        end
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        exp_q.delete();
        m_bytes.delete();
        m_adr = BASE;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_write_o"},  32'(write_o),  32'd0);
        chk({nm, "_adr_o"},    adr_o,         BASE);
        chk({nm, "_dat_o"},    dat_o,         32'd0);
        chk({nm, "_sel_o"},    32'(sel_o),    32'd0);
        chk({nm, "_level"},    32'(level),    32'd0);
        chk({nm, "_overflow"}, 32'(overflow), 32'd0);
        chk({nm, "_wrap"},     32'(wrap),     32'd0);
    endtask

    // ---------------- wishbone busy responder ----------------
    initial begin
        int bcnt;
        bcnt   = 0;
        busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_hold) begin
                busy_i = 1'b1;
            end else if (bcnt > 0) begin
                busy_i = 1'b1;
                bcnt--;
            end else begin
                busy_i = 1'b0;
            end
            if (write_o) bcnt = busy_len;
            if (!rst) bcnt = 0;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic        prev_rst;
        logic        prev_wr;
        logic [31:0] prev_adr;
        wr_t         e;
        prev_rst = 1'b0;
        prev_wr  = 1'b0;
        prev_adr = BASE;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                if (write_o) begin
                    chk("write_back_to_back", 32'(prev_wr), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write: adr %h dat %h sel %b, no word expected",
                                 adr_o, dat_o, sel_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_dat", dat_o,       e.dat);
                        chk("wr_sel", 32'(sel_o),  32'(e.sel));
                        chk("wr_adr", adr_o,       m_adr);
                    end
                    m_adr    = next_adr(m_adr);
                    last_dat = dat_o;
                    last_sel = sel_o;
                    last_adr = adr_o;
                end
                chk("wrap_pulse", 32'(wrap), 32'((prev_adr == LAST) && (adr_o == BASE)));
                if (wrap) wrap_cnt++;
            end
            prev_rst = rst;
            prev_wr  = write_o;
            prev_adr = adr_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequences ----------------
    initial begin
        rst          = 1'b0;
        enable       = 1'b0;
        sample_in    = 8'd0;
        sample_valid = 1'b0;
        flush        = 1'b0;
        step();
        step();
        step();
        chk_reset_vals("reset");
        rst    = 1'b1;
        enable = 1'b1;
        step();

        // One full word with the standard busy response
        word(8'h11, 8'h22, 8'h33, 8'h44);
        chk("word1_level_after_push", 32'(level), 32'd1);
        wait_drain("word1");
        chk("word1_dat", last_dat, 32'h4433_2211);
        chk("word1_sel", 32'(last_sel), 32'hF);
        chk("word1_adr", last_adr, 32'h3300_0000);
        chk("word1_adr_after", adr_o, 32'h3300_0004);
        chk("word1_level_after", 32'(level), 32'd0);

        // Partial words via flush
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        wait_drain("flush2");
        chk("flush2_dat", last_dat, 32'h0000_BBAA);
        chk("flush2_sel", 32'(last_sel), 32'h3);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b1, 8'hCC, 1'b1);
        wait_drain("flush3");
        chk("flush3_dat", last_dat, 32'h00CC_BBAA);
        chk("flush3_sel", 32'(last_sel), 32'h7);

        // Flush with nothing packed does nothing
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("flush0_level", 32'(level), 32'd0);

        // Word completed by a sample that coincides with flush: one push only
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h04, 1'b1);
        chk("flush4_single_push", 32'(level), 32'd1);
        wait_drain("flush4");
        chk("flush4_dat", last_dat, 32'h0403_0201);
        chk("flush4_wrap_count", 32'(wrap_cnt), 32'd1);
        chk("flush4_adr_wrapped", adr_o, BASE);

        // Ring wrap: five words from reset
        do_reset();
        wrap_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            word(8'(16*k), 8'(16*k + 1), 8'(16*k + 2), 8'(16*k + 3));
            wait_drain("ring");
        end
        chk("ring_wrap_count", 32'(wrap_cnt), 32'd1);
        chk("ring_last_adr", last_adr, 32'h3300_0000);
        chk("ring_last_dat", last_dat, 32'h4342_4140);
        chk("ring_adr_after", adr_o, 32'h3300_0004);

        // Overflow with the manager held busy
        do_reset();
        busy_hold = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            word(8'(16*k), 8'(16*k + 1), 8'(16*k + 2), 8'(16*k + 3));
            chk("ovf_level", 32'(level), 32'((k < DEPTH) ? k : DEPTH));
            chk("ovf_flag", 32'(overflow), 32'(k == 5));
        end
        step();
        chk("ovf_dat_held", dat_o, 32'h1312_1110);
        chk("ovf_adr_held", adr_o, BASE);
        busy_hold = 1'b0;
        do_reset();
        chk("ovf_cleared_by_reset", 32'(overflow), 32'd0);

        // Enable dropped during WAIT_DONE with two words queued
        busy_len = 10;
        word(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        word(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                if (busy_i) break;
                step();
            end
            if (k == 20) begin
                n_chk++;
                n_fail++;
                $display("FAIL endrop_busy_timeout: busy_i %0d, expected 1", busy_i);
            end
        end
        step();
        step();
        chk("endrop_level_before", 32'(level), 32'd2);
        enable = 1'b0;
        exp_q.delete();
        m_bytes.delete();
        step();
        chk("endrop_level_cleared", 32'(level), 32'd0);
        drive(1'b1, 8'h99, 1'b0);
        for (int k = 0; k < 20; k++) step();
        chk("endrop_adr", adr_o, 32'h3300_0004);
        chk("endrop_level_final", 32'(level), 32'd0);
        busy_len = 3;
        enable   = 1'b1;
        step();
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        wait_drain("resume");
        chk("resume_dat", last_dat, 32'h0003_0201);
        chk("resume_adr", last_adr, 32'h3300_0004);

        // Reset asserted during WAIT_START
        do_reset();
        word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                if (write_o) break;
                step();
            end
            if (k == 20) begin
                n_chk++;
                n_fail++;
                $display("FAIL rstws_write_timeout: write_o %0d, expected 1", write_o);
            end
        end
        rst = 1'b0;
        step();
        chk_reset_vals("rst_in_wait_start");
        exp_q.delete();
        m_bytes.delete();
        m_adr = BASE;
        step();
        rst = 1'b1;
        step();
        word(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        wait_drain("after_rst");
        chk("after_rst_adr", last_adr, 32'h3300_0000);
        chk("after_rst_dat", last_dat, 32'h5D5C_5B5A);

        chk("model_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/team_06_sample_packer.md
Name: team_06_sample_packer

Overview:
Sits between team_06_audio_effect and wishbone_manager. It accepts 8-bit processed audio samples, packs four consecutive samples into one 32-bit word and queues the words in a small FIFO. It then drives the manager's single-word write handshake to store them in a circular record region of SRAM. Holding a few words in the FIFO lets wishbone latency be absorbed without dropping samples.

Parameters:
BASE_ADDR, 32'h3300_0000, byte address of first word of ring region (word-aligned)
RING_WORDS, 2048, number of 32-bit words in ring; address wraps after last
FIFO_DEPTH, 4, number of packed words buffered (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
enable  in  1  recording enable from FSM; low = packer/FIFO cleared
sample_in  in  8  audio sample
sample_valid  in  1  one-cycle strobe; sample_in captured this cycle
flush  in  1  one-cycle strobe; push partial word (zero-padded)
busy_i  in  1  BUSY_O from wishbone_manager
write_o  out  1  WRITE_I to manager, single-cycle pulse
adr_o  out  32  ADR_I to manager
dat_o  out  32  CPU_DAT_I to manager
sel_o  out  4  SEL_I to manager, valid byte lanes
level  out  3  words currently in FIFO (0..FIFO_DEPTH)
overflow  out  1  sticky: packed word dropped because FIFO full
wrap  out  1  one-cycle pulse when address wraps to BASE_ADDR

Behaviour:
- Reset (rst=0 at posedge): write_o=0, adr_o=BASE_ADDR, dat_o=0, sel_o=0, level=0, overflow=0, wrap=0. Byte counter=0, FIFO empty, FSM=IDLE. Reset overrides everything, including an in-flight write; write_o is never asserted in the cycle after reset.
- Packing: little-endian. The 1st sample goes to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24]. sample_valid ignored while enable=0.
- On the 4th sample: word plus sel=4'b1111 pushed into the FIFO on the same edge; byte counter returns to 0.
- flush with byte count k=1..3: pushed word holds the valid bytes, other lanes zero, sel has the low k bits set. Flush with k=0 has no effect.
- sample_valid and flush in the same cycle: the sample is packed first, then the flush is applied. If the sample completes a word, only one push occurs.
- Push while FIFO full (level==FIFO_DEPTH): word dropped, overflow<=1, FIFO contents unchanged. overflow clears only when enable=0 or on reset.
- Write FSM, three states:
  - IDLE: if FIFO non-empty, present the head word on dat_o/sel_o, assert write_o for exactly one cycle, go to WAIT_START.
  - WAIT_START: hold adr_o/dat_o/sel_o stable; go to WAIT_DONE when busy_i=1.
  - WAIT_DONE: when busy_i=0, pop the FIFO and advance adr_o by 4, then return to IDLE.
- Address wrap: advancing from BASE_ADDR+4*(RING_WORDS-1) sets adr_o to BASE_ADDR and pulses wrap for 1 cycle.
- Minimum write spacing: one IDLE cycle between completions. Back-to-back FIFO words issue at most one write every 3 cycles plus manager busy time.
- Push and pop on the same edge: level unchanged. A push into a full FIFO coincident with a pop is accepted (no overflow).
- enable falls (enable=0):
  - Byte counter and FIFO clear next edge; overflow clears.
  - An in-flight transaction (WAIT_START/WAIT_DONE) completes normally with outputs held, then the FSM returns to IDLE without popping.
  - adr_o is not reset, so recording resumes at the next ring address.
- level is the registered FIFO occupancy, updated on the same edge as push/pop.

Test Plan:
- Reset, enable=1, feed 0x11,0x22,0x33,0x44 with busy model (busy_i high 3 cycles, starting 1 cycle after write_o) -> one write_o pulse, dat_o=0x44332211, sel_o=1111, adr_o=0x33000000; after busy falls, adr_o=0x33000004 and level=0.
- Feed 0xAA,0xBB then flush -> write with dat_o=0x0000BBAA, sel_o=0011; same-cycle sample 0xCC + flush after two bytes -> dat_o=0x00CCBBAA, sel_o=0111.
- Hold busy_i=1 forever, push 5 full words with FIFO_DEPTH=4 -> level saturates at 4 (one word consumed into the held transaction stays counted), overflow=1 on the first dropped word, dat_o unchanged.
- RING_WORDS=4: write 5 words -> addresses 0x33000000,04,08,0C,00; wrap pulses once when adr_o returns to 0x33000000.
- Drop enable during WAIT_DONE with 2 words queued -> current write completes, level=0 next edge, no further write_o, adr_o advanced by 4 only.
- Assert rst=0 during WAIT_START -> all outputs at reset values next edge; after release, first write goes to 0x33000000.
